// File: rtl/dac_sample_feeder_if.sv
// Producer-side write handshake for dac_sample_feeder.
// A word {wr_pd, wr_data} transfers on a clock where wr_valid & wr_ready.
interface dac_sample_feeder_if;
  logic [11:0] wr_data;
  logic [1:0]  wr_pd;
  logic        wr_valid;
  logic        wr_ready;

  modport master (
    output wr_data,
    output wr_pd,
    output wr_valid,
    input  wr_ready
  );

  modport slave (
    input  wr_data,
    input  wr_pd,
    input  wr_valid,
    output wr_ready
  );
endinterface

// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: sample FIFO and frame pacing ahead of the DACx311 serial driver.
// The driver's data/pd inputs change only on the edge where dac_ready is seen, so they stay
// stable for the whole serial frame that follows.
// Optional feature: define DAC_SAMPLE_FEEDER_RAMP_EN to add the 'ramp' test-pattern input.
module dac_sample_feeder #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  dac_sample_feeder_if.slave    wr,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  clr_stats,
  input  logic                  dac_ready,
`ifdef DAC_SAMPLE_FEEDER_RAMP_EN
  input  logic                  ramp,
`endif
  output logic [11:0]           dac_data,
  output logic [1:0]            dac_pd,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           underflow_cnt,
  output logic                  primed
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = DEPTH[DEPTH_LOG2:0];

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [13:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [0:0]            state;

  logic full;
  logic empty;
  logic ramp_active;
  logic flush_eff;
  logic wr_fire;
  logic pop;
  logic underflow;
  logic ramp_step;

  // Decode this cycle's FIFO and pacing events.
  always_comb begin
    full        = (level == LVL_FULL);
    empty       = (level == '0);
`ifdef DAC_SAMPLE_FEEDER_RAMP_EN
    ramp_active = ramp & enable;
`else
    ramp_active = 1'b0;
`endif
    // While ramping the FIFO is left alone, so flush is ignored too.
    flush_eff   = flush & ~ramp_active;
    wr_fire     = wr.wr_valid & ~full & ~flush_eff;
    pop         = dac_ready & enable & ~empty & ~flush_eff & ~ramp_active;
    underflow   = dac_ready & enable & empty & ~flush_eff & ~ramp_active;
    ramp_step   = dac_ready & ramp_active;
  end

  assign wr.wr_ready = ~full;
  assign primed      = (state == ST_RUN);

  // Sample storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr] <= {wr.wr_pd, wr.wr_data};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_eff) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_fire, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

  // Driver-facing outputs and IDLE/RUN state; only reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dac_data <= 12'd0;
      dac_pd   <= 2'b11;
      state    <= ST_IDLE;
    end else if (ramp_step) begin
      dac_data <= dac_data + 12'd1;
      dac_pd   <= 2'b00;
      state    <= ST_RUN;
    end else if (pop) begin
      {dac_pd, dac_data} <= mem[rd_ptr];
      state              <= ST_RUN;
    end
  end

  // Saturating underflow counter; a clear beats a same-cycle underflow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      underflow_cnt <= 16'd0;
    end else if (clr_stats) begin
      underflow_cnt <= 16'd0;
    end else if (underflow && underflow_cnt != 16'hFFFF) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: doc/dac_sample_feeder.md
# dac_sample_feeder

Sample buffer and pacing stage that sits directly upstream of the DACx311 serial driver. It accepts 14-bit sample words (2-bit power-down plus 12-bit code) from a producer through a valid/ready handshake and stores them in a small FIFO. It updates the driver's parallel `data`/`pd` inputs only in the cycle after the driver's `ready` pulse, so those inputs are stable for the whole serial frame. It also reports FIFO level and counts underflows.

## Interface
- `DEPTH_LOG2`, 4 — FIFO depth is 2**DEPTH_LOG2 words (16).
- `clk` in 1 — single clock; all logic on posedge.
- `reset` in 1 — synchronous, active-low; a 0 sampled at posedge resets the block.
- `wr_data` in 12 — sample code.
- `wr_pd` in 2 — power-down field stored with the sample.
- `wr_valid` in 1 — producer offers `{wr_pd, wr_data}`.
- `wr_ready` out 1 — combinational, equal to not-full; a transfer occurs when `wr_valid & wr_ready`.
- `enable` in 1 — 1 means pop FIFO on `dac_ready`; 0 means hold output, do not pop.
- `flush` in 1 — synchronous FIFO empty.
- `clr_stats` in 1 — clears `underflow_cnt`.
- `dac_ready` in 1 — 1-cycle pulse from the driver marking a frame boundary.
- `dac_data` out 12 — registered; to driver `data`.
- `dac_pd` out 2 — registered; to driver `pd`.
- `level` out DEPTH_LOG2+1 — registered FIFO occupancy, 0..2**DEPTH_LOG2.
- `underflow_cnt` out 16 — registered saturating underflow count.
- `primed` out 1 — registered; 1 once the first sample has been presented.

## Operation
- FIFO: circular buffer with read and write pointers of DEPTH_LOG2 bits each, wrapping modulo depth. Occupancy is held in `level`. Full means `level == 2**DEPTH_LOG2`; empty means `level == 0`. There is no fall-through: a word written in cycle N can be popped at the earliest in cycle N+1.
- Pop event: `dac_ready & enable & !empty`. The head word is loaded into `{dac_pd, dac_data}`, the read pointer advances, and `primed` is set to 1.
- Underflow event: `dac_ready & enable & empty`. Outputs hold their previous value and `underflow_cnt` increments, saturating at 65535.
- `dac_ready` while `enable == 0`: no pop and no count.
- State machine has two states:
  - IDLE (`primed == 0`): outputs are at reset values.
  - RUN (`primed == 1`): outputs hold the last popped word.
  - IDLE→RUN on the first pop. Only `reset` returns the block to IDLE.
- Simultaneous write and pop: both take effect and `level` is unchanged. When full, `wr_ready == 0` even if a pop occurs in the same cycle.
- Simultaneous write and underflow (FIFO empty): the write is stored, the underflow is counted, and outputs hold.
- `flush`: pointers and `level` go to 0 at the next edge. Outputs, `primed` and `underflow_cnt` are unchanged. Flush overrides any write or pop in the same cycle: the write is dropped and there is no pop and no underflow count.
- `clr_stats` in the same cycle as an underflow: the clear wins and the result is 0.

## Timing
- Reset values:
  - `dac_data = 0`
  - `dac_pd = 2'b11` (high-Z, safe until the first real sample)
  - `level = 0`, so `wr_ready = 1`
  - `underflow_cnt = 0`
  - `primed = 0`
  - FIFO pointers = 0
- Latency: `dac_ready` high at edge N, so new `dac_data`/`dac_pd` are visible after edge N. The outputs otherwise do not change until the next `dac_ready`.
- Minimum write-to-output latency: write at edge N, earliest pop at edge N+1 when `dac_ready` is high there.
- `level` and `underflow_cnt` update at the same edge as the causing event.
- Reset mid-operation: every register takes its reset value at that edge, regardless of `dac_ready`, `flush` or write activity. FIFO contents are discarded.

## Configuration
- `DAC_SAMPLE_FEEDER_RAMP_EN`:
  - Defined: an extra input port `ramp` (1 bit) exists. While `ramp == 1` and `enable == 1`, each `dac_ready` increments `dac_data` by 1, wrapping 4095→0. `dac_pd` is forced to 2'b00, `primed` is set to 1, the FIFO is neither popped nor flushed, writes are still accepted, and underflows are not counted.
  - Undefined: the `ramp` port is absent and behaviour is identical to `ramp == 0`.

## Test plan
- Reset, then idle. Required: `dac_data == 0`, `dac_pd == 3`, `level == 0`, `wr_ready == 1`, `primed == 0`.
- Write 0x123/pd0, 0x456/pd1, then three `dac_ready` pulses with `enable = 1`. Required outputs after each pulse: 0x123/0, then 0x456/1, then 0x456/1 held with `underflow_cnt == 1`. `level` goes 2→1→0.
- Write 17 words back-to-back. Required: `wr_ready` drops after the 16th and the 17th is not accepted. Draining returns words 1..16 in order with pointer wrap. `level` peaks at 16.
- With the FIFO full, pulse `dac_ready` and `wr_valid` in the same cycle. Required: pop occurs, write is refused, `level == 15`. Next cycle write succeeds and `level == 16`.
- With `level == 5`, assert `flush` together with a `wr_valid` write and a `dac_ready` pulse. Required: `level == 0`, outputs unchanged, `underflow_cnt` unchanged. Assert `clr_stats` together with an underflow. Required: `underflow_cnt == 0`.
- With the macro defined, `ramp = 1`, and `dac_data == 4094`, apply three `dac_ready` pulses. Required: 4095, then 0, then 1, with `dac_pd == 0`.
